resource_arbiter: RTL

- Shares one external resource port (LUT/memory read/write) between N_REQ resource-branch requesters.
- Each requester presents a level-held read_req/write_req with handle and args, and waits for read_ready or write_ack.
- The arbiter grants one requester round-robin, forwards its request to the resource, captures the response and returns it to the granted requester.
- Sits between the per-lane resource branches and the single shared resource controller.

---
 rtl/resource_arbiter_pkg.sv | 14 +
 rtl/resource_arbiter_rr_pick.sv | 30 +++
 rtl/resource_arbiter.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/resource_arbiter_pkg.sv
// rtl/resource_arbiter_pkg.sv - shared FSM state encoding and grant-index sizing for resource_arbiter
package resource_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_t;

  function automatic int grant_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/resource_arbiter_rr_pick.sv
// rtl/resource_arbiter_rr_pick.sv - combinational round-robin selector
// Returns the first pending index after i_last_grant, wrapping modulo N_REQ.
module rr_pick
  import resource_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int GW    = grant_width(N_REQ)
) (
  input  logic [N_REQ-1:0] i_pending,
  input  logic [GW-1:0]    i_last_grant,
  output logic [GW-1:0]    o_grant,
  output logic             o_any_pending
);

  logic [GW-1:0] w_idx;

  always_comb begin
    o_grant       = '0;
    o_any_pending = 1'b0;
    w_idx         = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = GW'((int'(i_last_grant) + k) % N_REQ);
      if (!o_any_pending && i_pending[w_idx]) begin
        o_any_pending = 1'b1;
        o_grant       = w_idx;
      end
    end
  end

endmodule

// File: rtl/resource_arbiter.sv
// rtl/resource_arbiter.sv - round-robin arbiter sharing one resource port among N_REQ requesters
// RESOURCE_ARBITER_TIMEOUT_EN adds an ISSUE watchdog and the sticky timeout_err output.
module resource_arbiter
  import resource_arbiter_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int data_width     = 16,
  parameter int handle_width   = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_REQ-1:0]               req_read,
  input  logic [N_REQ-1:0]               req_write,
  input  logic [N_REQ*handle_width-1:0]  req_handle,
  input  logic [N_REQ*data_width-1:0]    req_arg_a,
  input  logic [N_REQ*data_width-1:0]    req_arg_b,
  output logic [N_REQ-1:0]               req_read_ready,
  output logic [N_REQ-1:0]               req_write_ack,
  output logic [data_width-1:0]          req_data,
  output logic                           res_read_req,
  output logic                           res_write_req,
  output logic [handle_width-1:0]        res_handle,
  output logic [data_width-1:0]          res_arg_a,
  output logic [data_width-1:0]          res_arg_b,
  input  logic [data_width-1:0]          res_data_in,
  input  logic                           res_read_ready,
  input  logic                           res_write_ack,
`ifdef RESOURCE_ARBITER_TIMEOUT_EN
  output logic                           timeout_err,
`endif
  output logic                           busy
);

  localparam int GW = grant_width(N_REQ);
  localparam logic [GW-1:0] LAST_INIT = GW'(N_REQ - 1);

  arb_state_t       r_state;
  logic [GW-1:0]    r_grant;
  logic [GW-1:0]    r_last_grant;
  logic             r_is_write;
  logic [N_REQ-1:0] w_pending;
  logic [N_REQ-1:0] w_grant_oh;
  logic [N_REQ-1:0] w_pick_oh;
  logic [GW-1:0]    w_pick;
  logic             w_any;
  logic             w_pick_wr;
  logic             w_resp_hit;
  logic             w_tmo;

  assign w_pending  = req_read | req_write;
  assign w_grant_oh = N_REQ'(1) << r_grant;
  assign w_pick_oh  = N_REQ'(1) << w_pick;
  assign w_pick_wr  = |(req_write & w_pick_oh);
  assign w_resp_hit = r_is_write ? res_write_ack : res_read_ready;
  assign busy       = (r_state != ARB_IDLE);

  rr_pick #(.N_REQ(N_REQ), .GW(GW)) u_rr_pick (
    .i_pending     (w_pending),
    .i_last_grant  (r_last_grant),
    .o_grant       (w_pick),
    .o_any_pending (w_any)
  );

`ifdef RESOURCE_ARBITER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_tmo_cnt;

  assign w_tmo = (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tmo_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (r_state == ARB_ISSUE && !w_resp_hit) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
        if (w_tmo) timeout_err <= 1'b1;
      end else begin
        r_tmo_cnt <= '0;
      end
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ARB_IDLE;
      r_grant        <= '0;
      r_last_grant   <= LAST_INIT;
      r_is_write     <= 1'b0;
      res_read_req   <= 1'b0;
      res_write_req  <= 1'b0;
      res_handle     <= '0;
      res_arg_a      <= '0;
      res_arg_b      <= '0;
      req_read_ready <= '0;
      req_write_ack  <= '0;
      req_data       <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_state       <= ARB_ISSUE;
            r_grant       <= w_pick;
            r_last_grant  <= w_pick;
            r_is_write    <= w_pick_wr;
            res_write_req <= w_pick_wr;
            res_read_req  <= ~w_pick_wr;
            res_handle    <= req_handle[int'(w_pick)*handle_width +: handle_width];
            res_arg_a     <= req_arg_a[int'(w_pick)*data_width +: data_width];
            res_arg_b     <= req_arg_b[int'(w_pick)*data_width +: data_width];
          end
        end
        ARB_ISSUE: begin
          // Wrong-type responses never match w_resp_hit, so they are dropped here.
          if (w_resp_hit || w_tmo) begin
            r_state       <= ARB_RESP;
            res_read_req  <= 1'b0;
            res_write_req <= 1'b0;
            if (r_is_write) begin
              req_write_ack <= w_grant_oh;
            end else begin
              req_read_ready <= w_grant_oh;
              req_data       <= w_resp_hit ? res_data_in : '0;
            end
          end
        end
        ARB_RESP: begin
          // Hold the ack until the owner lets go, covering requesters stalled by their own enable.
          if (!(|(w_pending & w_grant_oh))) begin
            r_state        <= ARB_IDLE;
            req_read_ready <= '0;
            req_write_ack  <= '0;
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule
